event_prio_q: RTL and testbench

//  Parametrised min-priority queue for the PDES event scheduler: holds up to DEPTH
//  {key,payload} events, keys = timestamps. Head (smallest key) always presented
//  at the output. Systolic sorted array: one operation per cycle, no backpressure

---
 rtl/event_prio_q.sv | 149 ++++++++++++++
 tb/tb_event_prio_q.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_prio_q.sv
// event_prio_q: min-priority queue of {key,payload} events for the PDES scheduler.
// The queue is a systolic array of slots kept sorted in ascending key order.
// The smallest key is always in slot 0, and slot 0 drives the head outputs.
// It accepts one operation per cycle. Events with equal keys leave in arrival order.
// Optional feature: define PQ_REPLACE_EN to make enq+deq on a non-empty queue
// a single-cycle replace (pop head, push new). Without it, enq wins and deq is
// reported through deq_err.
module event_prio_q #(
  parameter int unsigned KW    = 16,
  parameter int unsigned PW    = 16,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          enq,
  input  logic          deq,
  input  logic [KW-1:0] in_key,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  output logic [KW-1:0] out_key,
  output logic [PW-1:0] out_payload,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          enq_drop,
  output logic          deq_err
);

  typedef struct packed {
    logic          v;
    logic [KW-1:0] key;
    logic [PW-1:0] payload;
  } slot_t;

  localparam slot_t EMPTY_SLOT = '{v: 1'b0, key: {KW{1'b1}}, payload: {PW{1'b0}}};

  slot_t         slot_q   [DEPTH];
  slot_t         slot_d   [DEPTH];
  slot_t         ins_slot [DEPTH];
  slot_t         del_slot [DEPTH];
  slot_t         new_slot;
  logic [DEPTH-1:0] g;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;
  logic          empty_c;

  assign new_slot = '{v: 1'b1, key: in_key, payload: in_payload};
  assign empty_c  = (count_q == '0);

  // Per-slot candidate next values for the insert and delete shifts.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    // g marks slots that stay ahead of the incoming event (ties stay ahead).
    assign g[i] = slot_q[i].v && (slot_q[i].key <= in_key);

    if (i == 0) begin : g_ins_head
      assign ins_slot[i] = g[0] ? slot_q[0] : new_slot;
    end else begin : g_ins_body
      assign ins_slot[i] = g[i] ? slot_q[i] : (g[i-1] ? new_slot : slot_q[i-1]);
    end

    if (i == DEPTH - 1) begin : g_del_tail
      assign del_slot[i] = EMPTY_SLOT;
    end else begin : g_del_body
      assign del_slot[i] = slot_q[i+1];
    end
  end

`ifdef PQ_REPLACE_EN
  slot_t rep_slot [DEPTH];

  // Replace: shift left over the entries that sort ahead of the new event, then drop it in.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rep
    if (i == 0) begin : g_rep_head
      assign rep_slot[i] = g[1] ? slot_q[1] : new_slot;
    end else if (i == DEPTH - 1) begin : g_rep_tail
      assign rep_slot[i] = g[i] ? new_slot : slot_q[i];
    end else begin : g_rep_body
      assign rep_slot[i] = g[i+1] ? slot_q[i+1] : (g[i] ? new_slot : slot_q[i]);
    end
  end
`endif

  // Select this cycle's operation and compute next slots, count and pulses.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    count_d = count_q;
    drop_d  = 1'b0;
    err_d   = 1'b0;

    if (enq && deq && !empty_c) begin
`ifdef PQ_REPLACE_EN
      for (int i = 0; i < DEPTH; i++) slot_d[i] = rep_slot[i];
`else
      err_d = 1'b1;
      if (full_q) begin
        drop_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) slot_d[i] = ins_slot[i];
        count_d = count_q + CW'(1);
      end
`endif
    end else if (enq) begin
      if (deq) err_d = 1'b1;
      if (full_q) begin
        drop_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) slot_d[i] = ins_slot[i];
        count_d = count_q + CW'(1);
      end
    end else if (deq) begin
      if (empty_c) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) slot_d[i] = del_slot[i];
        count_d = count_q - CW'(1);
      end
    end

    full_d = (count_d == CW'(DEPTH));
  end

  // State register with asynchronous clear of all slots and flags.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= EMPTY_SLOT;
      count_q <= '0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      count_q <= count_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = slot_q[0].v;
  assign out_key     = slot_q[0].key;
  assign out_payload = slot_q[0].payload;
  assign count       = count_q;
  assign full        = full_q;
  assign enq_drop    = drop_q;
  assign deq_err     = err_q;

endmodule

// File: tb/tb_event_prio_q.sv
// tb_event_prio_q: directed and random stimulus for event_prio_q, checked against a
// sorted-queue reference model. The bench follows PQ_REPLACE_EN the same way the DUT does.
module tb_event_prio_q;

  localparam int unsigned KW    = 16;
  localparam int unsigned PW    = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          CLK;
  logic          rst_n;
  logic          enq, deq;
  logic [KW-1:0] in_key;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic [KW-1:0] out_key;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] count;
  logic          full, enq_drop, deq_err;

  event_prio_q #(.KW(KW), .PW(PW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .rst_n(rst_n), .enq(enq), .deq(deq),
    .in_key(in_key), .in_payload(in_payload),
    .out_valid(out_valid), .out_key(out_key), .out_payload(out_payload),
    .count(count), .full(full), .enq_drop(enq_drop), .deq_err(deq_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [PW-1:0] pl;
  } ev_t;

  ev_t mq[$];
  bit  m_drop, m_err;
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stable insert: the new event goes after every queued event whose key is <= its key.
  function automatic void m_insert(input logic [KW-1:0] k, input logic [PW-1:0] p);
    ev_t e;
    int  pos;
    e.key = k;
    e.pl  = p;
    pos   = mq.size();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].key > k) begin
        pos = i;
        break;
      end
    end
    mq.insert(pos, e);
  endfunction

  function automatic void m_apply(input bit e, input bit d, input logic [KW-1:0] k,
                                  input logic [PW-1:0] p);
    bit is_empty, is_full;
    is_empty = (mq.size() == 0);
    is_full  = (mq.size() == DEPTH);
    m_drop   = 1'b0;
    m_err    = 1'b0;
    if (e && d && !is_empty) begin
`ifdef PQ_REPLACE_EN
      void'(mq.pop_front());
      m_insert(k, p);
`else
      m_err = 1'b1;
      if (is_full) m_drop = 1'b1;
      else m_insert(k, p);
`endif
    end else if (e) begin
      if (d) m_err = 1'b1;
      if (is_full) m_drop = 1'b1;
      else m_insert(k, p);
    end else if (d) begin
      if (is_empty) m_err = 1'b1;
      else void'(mq.pop_front());
    end
  endfunction

  task automatic check_all(input string tag);
    logic [KW-1:0] ek;
    logic [PW-1:0] ep;
    ek = '1;
    ep = '0;
    if (mq.size() != 0) begin
      ek = mq[0].key;
      ep = mq[0].pl;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".out_key"}, 32'(out_key), 32'(ek));
    chk({tag, ".out_payload"}, 32'(out_payload), 32'(ep));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".enq_drop"}, 32'(enq_drop), 32'(m_drop));
    chk({tag, ".deq_err"}, 32'(deq_err), 32'(m_err));
  endtask

  // Apply one operation across one posedge, update the model, check 1 time unit later.
  task automatic step(input string tag, input bit e, input bit d,
                      input logic [KW-1:0] k, input logic [PW-1:0] p);
    enq        = e;
    deq        = d;
    in_key     = k;
    in_payload = p;
    @(posedge CLK);
    m_apply(e, d, k, p);
    #1;
    enq = 1'b0;
    deq = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    enq        = 1'b0;
    deq        = 1'b0;
    in_key     = '0;
    in_payload = '0;
    m_drop     = 1'b0;
    m_err      = 1'b0;
    #12;
    // Reset state
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_key", 32'(out_key), 32'h0000_FFFF);
    chk("rst.out_payload", 32'(out_payload), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.enq_drop", 32'(enq_drop), 32'd0);
    chk("rst.deq_err", 32'(deq_err), 32'd0);
    rst_n = 1'b1;

    // Test 1: basic ordering
    step("t1.enq30", 1, 0, 16'd30, 16'd1);
    step("t1.enq10", 1, 0, 16'd10, 16'd2);
    step("t1.enq20", 1, 0, 16'd20, 16'd3);
    chk("t1.head_key", 32'(out_key), 32'd10);
    chk("t1.head_pl", 32'(out_payload), 32'd2);
    chk("t1.count3", 32'(count), 32'd3);
    step("t1.deq1", 0, 1, '0, '0);
    chk("t1.head20", 32'(out_key), 32'd20);
    chk("t1.pl3", 32'(out_payload), 32'd3);
    step("t1.deq2", 0, 1, '0, '0);
    chk("t1.head30", 32'(out_key), 32'd30);
    chk("t1.pl1", 32'(out_payload), 32'd1);
    step("t1.deq3", 0, 1, '0, '0);
    chk("t1.empty_valid", 32'(out_valid), 32'd0);
    chk("t1.empty_count", 32'(count), 32'd0);

    // Test 2: FIFO stability among equal keys
    step("t2.enqA", 1, 0, 16'd5, 16'hA);
    step("t2.enqB", 1, 0, 16'd5, 16'hB);
    step("t2.enqC", 1, 0, 16'd5, 16'hC);
    chk("t2.firstA", 32'(out_payload), 32'hA);
    step("t2.deq1", 0, 1, '0, '0);
    chk("t2.secondB", 32'(out_payload), 32'hB);
    step("t2.deq2", 0, 1, '0, '0);
    chk("t2.thirdC", 32'(out_payload), 32'hC);
    step("t2.deq3", 0, 1, '0, '0);

    // Test 3: fill to DEPTH, drop on full, then drain checking order
    for (int i = 0; i < DEPTH; i++) step("t3.fill", 1, 0, 16'(i), 16'(i + 100));
    chk("t3.full_set", 32'(full), 32'd1);
    step("t3.enq_full", 1, 0, 16'd7, 16'hBEEF);
    chk("t3.drop_pulse", 32'(enq_drop), 32'd1);
    chk("t3.count32", 32'(count), 32'd32);
    step("t3.idle", 0, 0, '0, '0);
    chk("t3.drop_clear", 32'(enq_drop), 32'd0);
    step("t3.deq", 0, 1, '0, '0);
    chk("t3.full_clear", 32'(full), 32'd0);
    chk("t3.count31", 32'(count), 32'd31);
    for (int i = 0; i < DEPTH - 1; i++) step("t3.drain", 0, 1, '0, '0);

    // Test 4: underflow, and enq with deq on empty
    step("t4.deq_empty", 0, 1, '0, '0);
    chk("t4.err_pulse", 32'(deq_err), 32'd1);
    chk("t4.count0", 32'(count), 32'd0);
    step("t4.enq_deq", 1, 1, 16'd9, 16'h9);
    chk("t4.head9", 32'(out_key), 32'd9);
    chk("t4.count1", 32'(count), 32'd1);
    chk("t4.err_again", 32'(deq_err), 32'd1);
    step("t4.deq", 0, 1, '0, '0);
    chk("t4.err_clear", 32'(deq_err), 32'd0);

    // Test 5: enq and deq on a non-empty queue
    step("t5.enq10", 1, 0, 16'd10, 16'd1);
    step("t5.enq20", 1, 0, 16'd20, 16'd2);
    step("t5.enq30", 1, 0, 16'd30, 16'd3);
    step("t5.both", 1, 1, 16'd15, 16'd4);
`ifdef PQ_REPLACE_EN
    chk("t5.rep_head15", 32'(out_key), 32'd15);
    chk("t5.rep_count3", 32'(count), 32'd3);
    chk("t5.rep_noerr", 32'(deq_err), 32'd0);
`else
    chk("t5.ew_head10", 32'(out_key), 32'd10);
    chk("t5.ew_count4", 32'(count), 32'd4);
    chk("t5.ew_err", 32'(deq_err), 32'd1);
`endif
    while (mq.size() != 0) step("t5.drain", 0, 1, '0, '0);
    for (int i = 0; i < DEPTH; i++) step("t5.fill", 1, 0, 16'(2 * i), 16'(i));
    step("t5.both_full", 1, 1, 16'd5, 16'h55);
`ifdef PQ_REPLACE_EN
    chk("t5.rep_full_nodrop", 32'(enq_drop), 32'd0);
    chk("t5.rep_full_count", 32'(count), 32'd32);
`else
    chk("t5.ew_full_drop", 32'(enq_drop), 32'd1);
    chk("t5.ew_full_err", 32'(deq_err), 32'd1);
`endif
    while (mq.size() != 0) step("t5.drain2", 0, 1, '0, '0);

    // Test 6: asynchronous reset in the middle of the stream
    step("t6.enq1", 1, 0, 16'd1, 16'd1);
    step("t6.enq2", 1, 0, 16'd2, 16'd2);
    step("t6.enq3", 1, 0, 16'd3, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_drop = 1'b0;
    m_err  = 1'b0;
    chk("t6.rst_valid", 32'(out_valid), 32'd0);
    chk("t6.rst_count", 32'(count), 32'd0);
    check_all("t6.rst");
    @(negedge CLK);
    rst_n = 1'b1;
    step("t6.enq4", 1, 0, 16'd4, 16'd4);
    chk("t6.head4", 32'(out_key), 32'd4);
    chk("t6.count1", 32'(count), 32'd1);

    // Random: alternating enq-heavy and deq-heavy phases, narrow key range for ties
    for (int n = 0; n < 3000; n++) begin
      bit ebias, e, d;
      ebias = ((n / 300) % 2) == 0;
      e = $urandom_range(0, 99) < (ebias ? 75 : 30);
      d = $urandom_range(0, 99) < (ebias ? 30 : 70);
      step("rnd", e, d, 16'($urandom_range(0, 40)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
